// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-cache port arbiter.
//   state_t  : sequencer states
//   REQ_IF / REQ_DM : requester ids
//   FUNC3_LW : access size used for instruction fetches (full word)
package mem_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_CHECK = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  localparam logic [2:0] FUNC3_LW = 3'b010;

endpackage

// File: rtl/mem_arb_prio.sv
// DM-priority selection with IF starvation protection.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   if_valid, dm_valid : pending requests from fetch and load/store
//   idle               : sequencer is in IDLE (grants only count there)
//   grant_fire         : a handshake happened this cycle
//   winner             : REQ_IF or REQ_DM, the port that may be granted
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int IF_MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic if_valid,
  input  logic dm_valid,
  input  logic idle,
  input  logic grant_fire,
  output logic winner
);

  localparam int SW = (IF_MAX_WAIT < 1) ? 1 : $clog2(IF_MAX_WAIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(IF_MAX_WAIT);

  logic [SW-1:0] starve_cnt;
  logic          fire;

  assign fire = idle && grant_fire;

  // IF only wins when DM is absent or IF has waited through IF_MAX_WAIT DM grants.
  always_comb begin
    winner = REQ_DM;
    if (if_valid && (!dm_valid || (starve_cnt == STARVE_MAX))) begin
      winner = REQ_IF;
    end
  end

  // No saturation needed: at STARVE_MAX with IF pending, IF wins and clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (!if_valid) begin
      starve_cnt <= '0;
    end else if (fire) begin
      starve_cnt <= (winner == REQ_IF) ? '0 : starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-cache port between instruction fetch (IF) and load/store (DM).
// One cache transaction at a time: IDLE -> ISSUE -> CHECK -> (WAIT) -> RESP,
// with DRAIN after a timeout until the cache releases busy.
// Ports:
//   clk, reset_n                       : clock, asynchronous active-low reset
//   if_req_* / if_addr / if_rsp_*      : fetch request/response (read-only, word)
//   dm_req_* / dm_addr/wdata/we/func3  : load/store request
//   dm_rsp_*                           : load/store response
//   cache_addr/wdata/we/func3          : request to the cache (we pulses once)
//   cache_rdata/hit/busy               : cache status and read data
//   hit_cnt / miss_cnt                 : wrapping performance counters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int IF_MAX_WAIT = 4,
  parameter int TIMEOUT     = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             if_req_valid,
  output logic             if_req_ready,
  input  logic [31:0]      if_addr,
  output logic             if_rsp_valid,
  output logic [31:0]      if_rsp_data,
  output logic             if_rsp_err,
  input  logic             dm_req_valid,
  output logic             dm_req_ready,
  input  logic [31:0]      dm_addr,
  input  logic [31:0]      dm_wdata,
  input  logic             dm_we,
  input  logic [2:0]       dm_func3,
  output logic             dm_rsp_valid,
  output logic [31:0]      dm_rsp_data,
  output logic             dm_rsp_err,
  output logic [31:0]      cache_addr,
  output logic [31:0]      cache_wdata,
  output logic             cache_we,
  output logic [2:0]       cache_func3,
  input  logic [31:0]      cache_rdata,
  input  logic             cache_hit,
  input  logic             cache_busy,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t state, state_nxt;

  logic        winner, idle, if_fire, dm_fire, grant_fire;
  logic [31:0] sel_addr, sel_wdata;
  logic        sel_we, sel_misaligned;
  logic [2:0]  sel_func3;

  logic        req_id_p0, req_we_p0;
  logic [31:0] req_addr_p0, req_wdata_p0;
  logic [2:0]  req_func3_p0;
  logic [31:0] rsp_data_p1;
  logic        rsp_err_p1, timeout_p1;
  logic [WAIT_W-1:0] wait_cnt;

  assign idle = (state == S_IDLE);

  mem_arb_prio #(
    .IF_MAX_WAIT(IF_MAX_WAIT)
  ) u_prio (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_valid  (if_req_valid),
    .dm_valid  (dm_req_valid),
    .idle      (idle),
    .grant_fire(grant_fire),
    .winner    (winner)
  );

  assign if_req_ready = idle && if_req_valid && (winner == REQ_IF);
  assign dm_req_ready = idle && dm_req_valid && (winner == REQ_DM);
  assign if_fire      = if_req_valid && if_req_ready;
  assign dm_fire      = dm_req_valid && dm_req_ready;
  assign grant_fire   = if_fire || dm_fire;

  // Fetches are presented to the cache as plain word loads.
  assign sel_addr       = (winner == REQ_DM) ? dm_addr  : if_addr;
  assign sel_wdata      = (winner == REQ_DM) ? dm_wdata : 32'd0;
  assign sel_we         = (winner == REQ_DM) ? dm_we    : 1'b0;
  assign sel_func3      = (winner == REQ_DM) ? dm_func3 : FUNC3_LW;
  assign sel_misaligned = (sel_addr[1:0] != 2'b00);

  // Cache request holds the latched values; only the write strobe pulses.
  assign cache_addr  = req_addr_p0;
  assign cache_wdata = req_wdata_p0;
  assign cache_func3 = req_func3_p0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cache_we     = 1'b0;
    if_rsp_valid = 1'b0;
    if_rsp_data  = 32'd0;
    if_rsp_err   = 1'b0;
    dm_rsp_valid = 1'b0;
    dm_rsp_data  = 32'd0;
    dm_rsp_err   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (grant_fire) begin
          state_nxt = sel_misaligned ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        cache_we  = req_we_p0;
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        state_nxt = cache_busy ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        if (!cache_busy || (wait_cnt == WAIT_LAST)) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (req_id_p0 == REQ_IF) begin
          if_rsp_valid = 1'b1;
          if_rsp_data  = rsp_data_p1;
          if_rsp_err   = rsp_err_p1;
        end else begin
          dm_rsp_valid = 1'b1;
          dm_rsp_data  = rsp_data_p1;
          dm_rsp_err   = rsp_err_p1;
        end
        state_nxt = timeout_p1 ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (!cache_busy) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // rsp_data_p1 is cleared at the handshake and only written on a successful
  // capture, so every error response carries zero data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_id_p0    <= REQ_IF;
      req_we_p0    <= 1'b0;
      req_addr_p0  <= '0;
      req_wdata_p0 <= '0;
      req_func3_p0 <= '0;
      rsp_data_p1  <= '0;
      rsp_err_p1   <= 1'b0;
      timeout_p1   <= 1'b0;
      wait_cnt     <= '0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
    end else begin
      unique case (state)
        // request latch
        S_IDLE: begin
          if (grant_fire) begin
            req_id_p0    <= winner;
            req_addr_p0  <= sel_addr;
            req_wdata_p0 <= sel_wdata;
            req_we_p0    <= sel_we;
            req_func3_p0 <= sel_func3;
            rsp_data_p1  <= '0;
            rsp_err_p1   <= sel_misaligned;
            timeout_p1   <= 1'b0;
          end
        end
        // cache status decode
        S_CHECK: begin
          wait_cnt <= '0;
          if (cache_hit) begin
            hit_cnt <= hit_cnt + 1'b1;
          end else if (cache_busy) begin
            miss_cnt <= miss_cnt + 1'b1;
          end
          if (!cache_busy) begin
            if (cache_hit) begin
              rsp_data_p1 <= cache_rdata;
            end else begin
              rsp_err_p1 <= 1'b1;
            end
          end
        end
        // completion capture
        S_WAIT: begin
          if (!cache_busy) begin
            rsp_data_p1 <= cache_rdata;
          end else begin
            if (wait_cnt == WAIT_LAST) begin
              rsp_err_p1 <= 1'b1;
              timeout_p1 <= 1'b1;
            end
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural cache alongside.
module tb_mem_port_arbiter;

  localparam int IF_MAX_WAIT = 4;
  localparam int TIMEOUT     = 64;
  localparam int CNT_W       = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req_valid = 1'b0, if_req_ready;
  logic [31:0] if_addr = '0;
  logic        if_rsp_valid, if_rsp_err;
  logic [31:0] if_rsp_data;
  logic        dm_req_valid = 1'b0, dm_req_ready;
  logic [31:0] dm_addr = '0, dm_wdata = '0;
  logic        dm_we = 1'b0;
  logic [2:0]  dm_func3 = '0;
  logic        dm_rsp_valid, dm_rsp_err;
  logic [31:0] dm_rsp_data;
  logic [31:0] cache_addr, cache_wdata;
  logic        cache_we;
  logic [2:0]  cache_func3;
  logic [31:0] cache_rdata = '0;
  logic        cache_hit = 1'b0, cache_busy = 1'b0;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .IF_MAX_WAIT(IF_MAX_WAIT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_func3(dm_func3),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data), .dm_rsp_err(dm_rsp_err),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_we(cache_we),
    .cache_func3(cache_func3), .cache_rdata(cache_rdata), .cache_hit(cache_hit),
    .cache_busy(cache_busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  typedef struct {
    bit          id;       // 1 = DM
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          we;
    logic [2:0]  func3;
    logic [31:0] data;
    bit          err;
    logic [31:0] hit;
    logic [31:0] miss;
    int          we_pulses;
    int          lat_kind; // 0 any, 1 exactly 3, 2 at most 2, 3 timeout path
    int          t_hs;
  } exp_t;

  exp_t        sbq[$];
  bit          grants[$];
  logic [31:0] mem [logic [31:0]];
  bit          present [logic [31:0]];
  logic [31:0] exp_hit = '0, exp_miss = '0;
  int          mode = 0;  // 0 normal cache, 1 stuck busy, 2 protocol error
  int          busy_cnt = 0;
  int          cyc = 0;
  int          n_checks = 0, n_pass = 0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_1234);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  task automatic fail(input string name, input int act, input int req);
    n_checks++;
    $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural cache: an access happens in the cycle after an aligned handshake.
  initial begin
    bit          pend, acc, we_s;
    logic [31:0] a_s, wd_s;
    logic [2:0]  f3_s;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      acc  = pend && reset_n;
      a_s  = cache_addr;
      wd_s = cache_wdata;
      we_s = cache_we;
      f3_s = cache_func3;
      if (acc) begin
        if (sbq.size() == 0) fail("cache_access_without_request", 1, 0);
        else begin
          check("cache_addr", a_s, sbq[0].addr);
          check("cache_func3", {29'd0, f3_s}, {29'd0, sbq[0].func3});
          if (sbq[0].we) check("cache_wdata", wd_s, sbq[0].wdata);
        end
      end
      pend = reset_n &&
             ((if_req_valid && if_req_ready && if_addr[1:0] == 2'b00) ||
              (dm_req_valid && dm_req_ready && dm_addr[1:0] == 2'b00));
      @(posedge clk);
      #1;
      if (!reset_n) begin
        busy_cnt = 0;
        acc = 1'b0;
        pend = 1'b0;
      end
      if (busy_cnt > 0) busy_cnt--;
      if (acc) begin
        if (mode == 2) begin
          cache_hit = 1'b0;
          busy_cnt  = 0;
        end else if (mode == 1) begin
          cache_hit = 1'b0;
          busy_cnt  = 100;
        end else begin
          cache_hit   = present.exists(a_s);
          cache_rdata = rd(a_s);
          busy_cnt    = cache_hit ? (we_s ? 2 : 0) : 5;
          if (we_s) mem[a_s] = wd_s;
          present[a_s] = 1'b1;
        end
      end
      cache_busy = (busy_cnt > 0);
    end
  end

  // Monitor: grants push expectations computed from the cache contents; responses pop.
  initial begin
    int   tb_starve, we_cnt, lat;
    bit   prev_we, hs_if, hs_dm, exp_dm;
    exp_t e;
    logic [31:0] a, got_data;
    bit   got_err;
    tb_starve = 0; we_cnt = 0; prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        sbq.delete();
        tb_starve = 0; we_cnt = 0; prev_we = 1'b0;
        exp_hit = '0; exp_miss = '0;
        continue;
      end
      if (cache_we) begin
        we_cnt++;
        if (prev_we) fail("cache_we_single_cycle", 2, 1);
      end
      prev_we = cache_we;

      if (if_rsp_valid || dm_rsp_valid) begin
        if (if_rsp_valid && dm_rsp_valid) fail("rsp_both_ports", 1, 0);
        else if (sbq.size() == 0) fail("rsp_unexpected", 1, 0);
        else begin
          e = sbq.pop_front();
          got_data = e.id ? dm_rsp_data : if_rsp_data;
          got_err  = e.id ? dm_rsp_err  : if_rsp_err;
          check("rsp_port_dm", {31'd0, dm_rsp_valid}, {31'd0, e.id});
          check("rsp_data", got_data, e.data);
          check("rsp_err", {31'd0, got_err}, {31'd0, e.err});
          check("hit_cnt", hit_cnt, e.hit);
          check("miss_cnt", miss_cnt, e.miss);
          check("cache_we_pulses", we_cnt, e.we_pulses);
          lat = cyc - e.t_hs;
          if (e.lat_kind == 1) check("read_hit_latency", lat, 3);
          if (e.lat_kind == 2) check("misaligned_latency_le2", {31'd0, lat <= 2}, 32'd1);
          if (e.lat_kind == 3) check("timeout_latency", lat, TIMEOUT + 3);
        end
      end

      hs_if = if_req_valid && if_req_ready;
      hs_dm = dm_req_valid && dm_req_ready;
      if (if_req_ready && !if_req_valid) fail("if_ready_without_valid", 1, 0);
      if (dm_req_ready && !dm_req_valid) fail("dm_ready_without_valid", 1, 0);
      if (if_req_valid && dm_req_valid && sbq.size() == 0 && !cache_busy &&
          !if_rsp_valid && !dm_rsp_valid && !hs_if && !hs_dm && prev_we == 1'b0 && busy_cnt == 0 &&
          cache_hit == 1'b0 && mode == 3)
        fail("no_grant", 0, 1);
      if (hs_if || hs_dm) begin
        check("single_grant", {31'd0, hs_if && hs_dm}, 32'd0);
        exp_dm = !(if_req_valid && (!dm_req_valid || tb_starve == IF_MAX_WAIT));
        check("grant_winner_dm", {31'd0, hs_dm}, {31'd0, exp_dm});
        check("grant_while_cache_busy", {31'd0, cache_busy}, 32'd0);
        check("grant_while_outstanding", sbq.size(), 0);
        grants.push_back(hs_dm);
        a         = hs_dm ? dm_addr : if_addr;
        e.id      = hs_dm;
        e.addr    = a;
        e.wdata   = dm_wdata;
        e.we      = hs_dm && dm_we;
        e.func3   = hs_dm ? dm_func3 : 3'b010;
        e.data    = '0;
        e.err     = 1'b0;
        e.lat_kind = 0;
        e.t_hs    = cyc;
        if (a[1:0] != 2'b00) begin
          e.err = 1'b1;
          e.lat_kind = 2;
        end else if (mode == 2) begin
          e.err = 1'b1;
        end else if (mode == 1) begin
          e.err = 1'b1;
          exp_miss++;
          e.lat_kind = 3;
        end else if (present.exists(a)) begin
          exp_hit++;
          e.data = rd(a);
          if (!e.we) e.lat_kind = 1;
        end else begin
          exp_miss++;
          e.data = rd(a);
        end
        e.hit  = exp_hit;
        e.miss = exp_miss;
        e.we_pulses = (e.we && a[1:0] == 2'b00) ? 1 : 0;
        sbq.push_back(e);
        we_cnt = 0;
      end
      if (!if_req_valid || hs_if) tb_starve = 0;
      else if (hs_dm) tb_starve++;
    end
  end

  task automatic drive_dm(input logic [31:0] a, input logic [31:0] wd, input bit we,
                          input logic [2:0] f3);
    int n = 0;
    dm_req_valid = 1'b1; dm_addr = a; dm_wdata = wd; dm_we = we; dm_func3 = f3;
    do begin @(negedge clk); n++; end while (!dm_req_ready && n < 500);
    if (!dm_req_ready) fail("dm_ready_wait_expired", n, 500);
    @(posedge clk); #1;
    dm_req_valid = 1'b0;
  endtask

  task automatic drive_if(input logic [31:0] a);
    int n = 0;
    if_req_valid = 1'b1; if_addr = a;
    do begin @(negedge clk); n++; end while (!if_req_ready && n < 500);
    if (!if_req_ready) fail("if_ready_wait_expired", n, 500);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while (sbq.size() != 0 && n < 500) begin @(posedge clk); n++; end
    if (sbq.size() != 0) fail("response_wait_expired", n, 500);
    #1;
  endtask

  task automatic gap(input int g);
    repeat (g) begin @(posedge clk); #1; end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_if_req_ready"}, {31'd0, if_req_ready}, 32'd0);
    check({tag, "_dm_req_ready"}, {31'd0, dm_req_ready}, 32'd0);
    check({tag, "_if_rsp_valid"}, {31'd0, if_rsp_valid}, 32'd0);
    check({tag, "_dm_rsp_valid"}, {31'd0, dm_rsp_valid}, 32'd0);
    check({tag, "_rsp_data"}, if_rsp_data | dm_rsp_data, 32'd0);
    check({tag, "_rsp_err"}, {30'd0, if_rsp_err, dm_rsp_err}, 32'd0);
    check({tag, "_cache_addr"}, cache_addr, 32'd0);
    check({tag, "_cache_wdata"}, cache_wdata, 32'd0);
    check({tag, "_cache_we_func3"}, {28'd0, cache_we, cache_func3}, 32'd0);
    check({tag, "_hit_cnt"}, hit_cnt, 32'd0);
    check({tag, "_miss_cnt"}, miss_cnt, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
    else a = 32'h40 + 32'($urandom_range(0, 15)) * 4;
    if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    present[32'h40] = 1'b1;
    mem[32'h40] = 32'hCAFE_F00D;
    mem[32'h80] = 32'hDEAD_BEEF;
    present[32'h44] = 1'b1;
    present[32'h48] = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset_n = 1'b1;
    gap(2);

    // read hit, read miss, store hit, read-back
    drive_dm(32'h40, 32'h0, 1'b0, 3'b010); wait_quiet();
    drive_dm(32'h80, 32'h0, 1'b0, 3'b010); wait_quiet();
    drive_dm(32'h40, 32'h1234_5678, 1'b1, 3'b010); wait_quiet();
    drive_dm(32'h40, 32'h0, 1'b0, 3'b010); wait_quiet();
    check("readback_mem", rd(32'h40), 32'h1234_5678);

    // misaligned fetch, then cache protocol error
    drive_if(32'h42); wait_quiet();
    mode = 2;
    drive_if(32'h44); wait_quiet();
    mode = 0;

    // starvation: both ports valid back to back
    grants.delete();
    fork
      repeat (2) drive_if(32'h44);
      repeat (12) drive_dm(32'h48, 32'h0, 1'b0, 3'b100);
    join
    wait_quiet();
    if (grants.size() < 10) fail("starve_grant_count", grants.size(), 14);
    else for (int i = 0; i < 10; i++)
      check($sformatf("starve_order_%0d", i), {31'd0, grants[i]},
            {31'd0, !(i == 4 || i == 9)});

    // randomized traffic on both ports
    fork
      for (int i = 0; i < 40; i++) begin
        gap($urandom_range(0, 3));
        drive_if(rand_addr());
      end
      for (int j = 0; j < 60; j++) begin
        gap($urandom_range(0, 3));
        drive_dm(rand_addr(), $urandom, ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
      end
    join
    wait_quiet();

    // timeout then drain, followed by a normal hit
    mode = 1;
    drive_dm(32'h500, 32'h0, 1'b0, 3'b010); wait_quiet();
    mode = 0;
    drive_dm(32'h44, 32'h0, 1'b0, 3'b010); wait_quiet();

    // reset while waiting on the cache
    mode = 1;
    drive_dm(32'h600, 32'h0, 1'b0, 3'b010);
    repeat (10) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    mode = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("post_reset_no_rsp", {30'd0, if_rsp_valid, dm_rsp_valid}, 32'd0);
    end
    @(posedge clk); #1;
    drive_dm(32'h40, 32'h0, 1'b0, 3'b010); wait_quiet();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
